calc_alu_sequencer: RTL and testbench

//  Multi-cycle arithmetic engine sequencer for the calculator datapath.

---
 rtl/calc_alu_sequencer_if.sv | 26 ++
 rtl/calc_alu_sequencer.sv | 162 ++++++++++++++++
 tb/tb_calc_alu_sequencer.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/calc_alu_sequencer_if.sv
// Request/result handshake bundle for the calculator ALU sequencer.
// The master side issues operations and consumes results; the slave side is the engine.
interface calc_alu_sequencer_if #(
  parameter int unsigned WIDTH = 8
);
  logic                 req_valid;
  logic                 req_ready;
  logic [2:0]           req_op;
  logic [WIDTH-1:0]     req_a;
  logic [WIDTH-1:0]     req_b;
  logic                 res_valid;
  logic                 res_ready;
  logic [2*WIDTH-1:0]   res_data;
  logic                 res_error;
  logic [2:0]           res_op;

  modport master (
    output req_valid, req_op, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_data, res_error, res_op
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, res_ready,
    output req_ready, res_valid, res_data, res_error, res_op
  );
endinterface

// File: rtl/calc_alu_sequencer.sv
// Multi-cycle ALU sequencer: single-cycle ADD/SUB, iterative shift-add MUL and
// restoring DIV, with valid/ready handshakes on both request and result sides.
module calc_alu_sequencer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 clear,
  calc_alu_sequencer_if.slave  bus,
  output logic                 busy
);
  localparam int unsigned W     = WIDTH;
  localparam int unsigned W2    = 2 * WIDTH;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_MUL = 3'd3;
  localparam logic [2:0] OP_DIV = 3'd4;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_e;

  state_e             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       b_q, b_d;
  logic [W2-1:0]      acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               iter_q, iter_d;
  logic               req_ready_q, req_ready_d;
  logic               res_valid_q, res_valid_d;
  logic [W2-1:0]      res_data_q, res_data_d;
  logic               res_error_q, res_error_d;
  logic [2:0]         res_op_q, res_op_d;

  logic [W:0]         add_sum;
  logic [W:0]         mul_sum;
  logic [W:0]         div_rem;
  logic               div_ge;
  logic [W-1:0]       div_sub;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    iter_d      = iter_q;
    req_ready_d = req_ready_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_error_d = res_error_q;
    res_op_d    = res_op_q;

    // acc holds {partial product, remaining multiplier} for MUL and
    // {partial remainder, dividend/quotient bits} for DIV.
    add_sum = {1'b0, a_q} + {1'b0, b_q};
    mul_sum = {1'b0, acc_q[W2-1:W]} + (acc_q[0] ? {1'b0, a_q} : '0);
    div_rem = {acc_q[W2-1:W], acc_q[W-1]};
    div_ge  = (div_rem >= {1'b0, b_q});
    div_sub = div_rem[W-1:0] - b_q;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          op_d        = bus.req_op;
          a_d         = bus.req_a;
          b_d         = bus.req_b;
          cnt_d       = '0;
          iter_d      = (bus.req_op == OP_MUL) ||
                        ((bus.req_op == OP_DIV) && (bus.req_b != '0));
          acc_d       = (bus.req_op == OP_DIV) ? {{W{1'b0}}, bus.req_a}
                                               : {{W{1'b0}}, bus.req_b};
          req_ready_d = 1'b0;
          state_d     = EXEC;
        end
      end
      EXEC: begin
        if (iter_q && (cnt_q != CNT_W'(W))) begin
          if (op_q == OP_MUL) begin
            acc_d = {mul_sum, acc_q[W-1:1]};
          end else begin
            acc_d = {(div_ge ? div_sub : div_rem[W-1:0]), acc_q[W-2:0], div_ge};
          end
          cnt_d = cnt_q + 1'b1;
        end else begin
          res_op_d    = op_q;
          res_error_d = 1'b0;
          res_data_d  = '0;
          case (op_q)
            OP_ADD: res_data_d = {{(W-1){1'b0}}, add_sum};
            OP_SUB: begin
              if (a_q >= b_q) res_data_d = {{W{1'b0}}, a_q - b_q};
              else            res_error_d = 1'b1;
            end
            OP_MUL: res_data_d = acc_q;
            OP_DIV: begin
              if (b_q == '0) res_error_d = 1'b1;
              else           res_data_d  = acc_q;
            end
            default: res_error_d = 1'b1;
          endcase
          res_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          res_data_d  = '0;
          res_error_d = 1'b0;
          res_op_d    = '0;
          req_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q     <= IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      iter_q      <= 1'b0;
      req_ready_q <= 1'b1;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_error_q <= 1'b0;
      res_op_q    <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      iter_q      <= iter_d;
      req_ready_q <= req_ready_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_error_q <= res_error_d;
      res_op_q    <= res_op_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_error = res_error_q;
  assign bus.res_op    = res_op_q;
  assign busy          = ~req_ready_q;

endmodule

// File: tb/tb_calc_alu_sequencer.sv
// Self-checking bench for calc_alu_sequencer: directed cases plus randomized
// operations compared against an arithmetic reference model.
module tb_calc_alu_sequencer;
  localparam int unsigned WIDTH = 8;

  logic clk = 1'b0;
  logic clear;
  logic busy;

  int unsigned n_cmp = 0;
  int unsigned n_mis = 0;

  calc_alu_sequencer_if #(.WIDTH(WIDTH)) bus ();

  calc_alu_sequencer #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Returns {error, data}
  function automatic logic [16:0] model(input int unsigned op, input int unsigned a,
                                        input int unsigned b);
    int unsigned d;
    logic        e;
    d = 0;
    e = 1'b0;
    case (op)
      1: d = a + b;
      2: if (a >= b) d = a - b; else e = 1'b1;
      3: d = a * b;
      4: if (b == 0) e = 1'b1; else d = (a % b) * 256 + (a / b);
      default: e = 1'b1;
    endcase
    return {e, d[15:0]};
  endfunction

  task automatic idle_outputs(input string tag);
    check({tag, "_valid"}, 32'(bus.res_valid), 32'd0);
    check({tag, "_data"},  32'(bus.res_data),  32'd0);
    check({tag, "_err"},   32'(bus.res_error), 32'd0);
    check({tag, "_op"},    32'(bus.res_op),    32'd0);
    check({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
    check({tag, "_busy"},  32'(busy),          32'd0);
  endtask

  // Entered and left #1 after a rising edge with the engine idle.
  task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input int unsigned stall);
    logic [16:0]  exp;
    int unsigned  exp_lat;
    int unsigned  lat;
    logic [15:0]  held;
    exp     = model(int'(op), int'(a), int'(b));
    exp_lat = (op == 3'd3 || (op == 3'd4 && b != 8'd0)) ? WIDTH + 1 : 1;

    check("pre_ready", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.res_ready = (stall == 0);
    @(posedge clk); #1;
    // Junk on the request lines must be ignored once accepted.
    bus.req_valid = 1'b1;
    bus.req_op    = 3'($urandom);
    bus.req_a     = 8'($urandom);
    bus.req_b     = 8'($urandom);
    check("acc_ready", 32'(bus.req_ready), 32'd0);
    check("acc_busy",  32'(busy),          32'd1);

    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (!bus.res_valid) check("wait_data0", 32'(bus.res_data), 32'd0);
    end while (!bus.res_valid && lat < 40);
    bus.req_valid = 1'b0;

    check("latency",  lat,                   exp_lat);
    check("res_data", 32'(bus.res_data),     32'(exp[15:0]));
    check("res_err",  32'(bus.res_error),    32'(exp[16]));
    check("res_op",   32'(bus.res_op),       32'(op));
    check("done_rdy", 32'(bus.req_ready),    32'd0);
    held = bus.res_data;

    for (int unsigned i = 0; i < stall; i++) begin
      bus.req_valid = 1'b1;
      bus.req_op    = 3'd1;
      @(posedge clk); #1;
      check("hold_valid", 32'(bus.res_valid), 32'd1);
      check("hold_data",  32'(bus.res_data),  32'(held));
      check("hold_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.req_valid = 1'b0;
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    idle_outputs("taken");
    bus.res_ready = 1'b0;
  endtask

  initial begin
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    clear         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    clear = 1'b0;
    idle_outputs("reset");

    run_op(3'd1, 8'd7,   8'd9,   0);
    run_op(3'd2, 8'd3,   8'd5,   0);
    run_op(3'd2, 8'd200, 8'd55,  0);
    run_op(3'd3, 8'd12,  8'd11,  0);
    run_op(3'd3, 8'd255, 8'd255, 0);
    run_op(3'd4, 8'd200, 8'd7,   0);
    run_op(3'd4, 8'd9,   8'd0,   0);
    run_op(3'd6, 8'd1,   8'd2,   0);
    run_op(3'd3, 8'd77,  8'd3,   5);
    run_op(3'd1, 8'd255, 8'd255, 2);

    // Abort a multiply in its 4th EXEC cycle.
    bus.req_valid = 1'b1;
    bus.req_op    = 3'd3;
    bus.req_a     = 8'd99;
    bus.req_b     = 8'd88;
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_clr_valid", 32'(bus.res_valid), 32'd0);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    bus.res_ready = 1'b0;
    idle_outputs("clr");
    run_op(3'd1, 8'd1, 8'd1, 0);

    for (int unsigned n = 0; n < 60; n++) begin
      op = 3'($urandom_range(0, 7));
      a  = 8'($urandom);
      b  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      run_op(op, a, b, $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
